pm_encoder: RTL
===============

# pm_encoder

Program-memory writer for the picoMIPS core: the encode side of the instruction decoder. It accepts assembler-level instruction fields (opcode, destination register, source register, immediate) over a valid/ready handshake and packs each one into an instruction word. It writes the words to consecutive program-memory addresses starting at 0, and holds the core off until the image is complete. It sits between the host/boot loader and the program memory that the PC and decoder read.

## Interface
- n, 8, data/immediate width (matches the datapath)
- RA, 3, register-address width
- AW, 5, program-memory address width; DEPTH = 2^AW words
- W (derived, not overridable) = 4 + 2*RA + n, instruction word width; 18 at defaults

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  single-cycle pulse, begins a new image at address 0
- finish  in  1  single-cycle pulse, closes the image
- in_valid  in  1  instruction fields valid
- in_ready  out  1  block can accept fields this cycle
- in_op  in  4  opcode, values per opcodes.sv
- in_rd  in  RA  destination register
- in_rs  in  RA  source register
- in_imm  in  n  immediate
- pm_we  out  1  program-memory write strobe
- pm_addr  out  AW  write address
- pm_wdata  out  W  word = {op[W-1:W-4], rd, rs, imm[n-1:0]}
- core_hold  out  1  high while an image is being loaded; gates PC start
- done  out  1  image closed normally or by full
- full  out  1  all DEPTH words written
- err  out  1  sticky, unknown opcode received
- count  out  AW+1  words written in the current image

## Operation
- States: IDLE, LOAD, DONE, ERROR.
- IDLE: in_ready=0, core_hold=0.
- start in any state: go to LOAD, address=0, count=0, done/full/err cleared.
- LOAD: in_ready=1 and core_hold=1.
- Transfer occurs when in_valid & in_ready at a clock edge.
- Field canonicalisation on transfer:
  - ADD, MUL: imm forced to 0.
  - INPM, ADDI, MULI: rs forced to 0.
  - INSW: rs and imm forced to 0.
  - SW80, SW81: rd, rs and imm forced to 0.
  - Store: fields passed unchanged.
- Unknown opcode: the transfer completes but no write is made. err=1, state goes to ERROR; in_ready=0 and core_hold=1 until start or reset.
- Valid transfer: the word is written at the current address, then address+1 and count+1.
- The write to address DEPTH-1 causes a transition to DONE with full=1 and count=DEPTH.
- finish in LOAD: go to DONE. A transfer in the same cycle is still written and counted.
- DONE: in_ready=0, core_hold=0, done=1. finish in IDLE or DONE is ignored.
- start and finish in the same cycle: start wins.

## Timing
- Reset values: in_ready=0, pm_we=0, pm_addr=0, pm_wdata=0, core_hold=0, done=0, full=0, err=0, count=0; state IDLE.
- Write latency is 1 cycle. A transfer at edge k drives pm_we=1 with registered pm_addr/pm_wdata for exactly the cycle after edge k. pm_addr and pm_wdata hold their last values when pm_we=0.
- Back-to-back transfers are sustained at 1 word/cycle with no bubbles.
- in_ready is a registered function of state only and never depends on in_valid.
- count, done and full update at the same edge that raises the corresponding pm_we.
- The core_hold falling edge coincides with done rising.
- Reset mid-image: the pending write is dropped (pm_we=0 in the following cycle) and the block returns to IDLE.
- start mid-image: the pending write from the previous cycle still completes; the next transfer writes address 0.

## Test plan
- Reset, then start, then ADDI rd=2 imm=8'h35 with valid held 1 cycle -> next cycle pm_we=1, pm_addr=0, pm_wdata={`ADDI,3'd2,3'd0,8'h35}; count=1.
- Back-to-back ADD rd=1 rs=3 imm=8'hFF, then SW81 rd=5, then finish in the same cycle as the SW81 transfer -> ADD written at address 0 with imm=0; SW81 written at address 1 with fields 0; done=1, count=2, core_hold=0.
- 32 consecutive MULI transfers -> addresses 0..31 written; full=1, done=1, count=32 after the last write; in_ready=0; a further in_valid causes no write.
- Unknown opcode at address 3 -> no pm_we that cycle; err=1 and state ERROR, core_hold=1; a subsequent start clears err and the next transfer writes address 0.
- Reset asserted the cycle after a transfer -> pm_we=0; all outputs at reset values; in_ready=0.
- start and finish asserted together in DONE -> state LOAD, count=0, done=0.

Source files
------------

// File: rtl/pm_encoder.sv
// picoMIPS program-memory writer: packs instruction fields into words
// and streams them to consecutive addresses while holding the core off.
module pm_encoder #(
  parameter int n  = 8,
  parameter int RA = 3,
  parameter int AW = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  finish,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [RA-1:0]         in_rd,
  input  logic [RA-1:0]         in_rs,
  input  logic [n-1:0]          in_imm,
  output logic                  pm_we,
  output logic [AW-1:0]         pm_addr,
  output logic [4+2*RA+n-1:0]   pm_wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic                  full,
  output logic                  err,
  output logic [AW:0]           count
);

  localparam int W = 4 + 2*RA + n;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_MUL   = 4'd1;
  localparam logic [3:0] OP_ADDI  = 4'd2;
  localparam logic [3:0] OP_MULI  = 4'd3;
  localparam logic [3:0] OP_INPM  = 4'd4;
  localparam logic [3:0] OP_INSW  = 4'd5;
  localparam logic [3:0] OP_SW80  = 4'd6;
  localparam logic [3:0] OP_SW81  = 4'd7;
  localparam logic [3:0] OP_STORE = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [W-1:0]  r_wdata;
  logic [AW:0]   r_count;
  logic          r_done;
  logic          r_full;
  logic          r_err;

  logic          w_xfer;
  logic          w_known;
  logic [RA-1:0] w_rd;
  logic [RA-1:0] w_rs;
  logic [n-1:0]  w_imm;
  logic [W-1:0]  w_word;
  logic          w_we_nx;
  logic [AW:0]   w_count_nx;
  logic          w_done_nx;
  logic          w_full_nx;
  logic          w_err_nx;
  logic          w_last;

  always_comb begin
    w_known = 1'b1;
    w_rd    = in_rd;
    w_rs    = in_rs;
    w_imm   = in_imm;
    case (in_op)
      OP_ADD, OP_MUL: w_imm = '0;
      OP_INPM, OP_ADDI, OP_MULI: w_rs = '0;
      OP_INSW: begin
        w_rs  = '0;
        w_imm = '0;
      end
      OP_SW80, OP_SW81: begin
        w_rd  = '0;
        w_rs  = '0;
        w_imm = '0;
      end
      OP_STORE: w_known = 1'b1;
      default: w_known = 1'b0;
    endcase
    w_word = {in_op, w_rd, w_rs, w_imm};
  end

  assign w_xfer = in_valid & in_ready;
  // The address is the low bits of the word count for this image.
  assign w_last = (r_count[AW-1:0] == {AW{1'b1}});

  always_comb begin
    w_state_nx = r_state;
    w_we_nx    = 1'b0;
    w_count_nx = r_count;
    w_done_nx  = r_done;
    w_full_nx  = r_full;
    w_err_nx   = r_err;
    if (start) begin
      w_state_nx = S_LOAD;
      w_count_nx = '0;
      w_done_nx  = 1'b0;
      w_full_nx  = 1'b0;
      w_err_nx   = 1'b0;
    end else if (r_state == S_LOAD) begin
      if (w_xfer && !w_known) begin
        w_state_nx = S_ERROR;
        w_err_nx   = 1'b1;
      end else begin
        if (w_xfer) begin
          w_we_nx    = 1'b1;
          w_count_nx = r_count + (AW+1)'(1);
          if (w_last) begin
            w_state_nx = S_DONE;
            w_full_nx  = 1'b1;
            w_done_nx  = 1'b1;
          end
        end
        if (finish) begin
          w_state_nx = S_DONE;
          w_done_nx  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_we    <= w_we_nx;
      if (w_we_nx) begin
        r_addr  <= r_count[AW-1:0];
        r_wdata <= w_word;
      end
      r_count <= w_count_nx;
      r_done  <= w_done_nx;
      r_full  <= w_full_nx;
      r_err   <= w_err_nx;
    end
  end

  assign in_ready  = (r_state == S_LOAD);
  assign core_hold = (r_state == S_LOAD) || (r_state == S_ERROR);
  assign pm_we     = r_we;
  assign pm_addr   = r_addr;
  assign pm_wdata  = r_wdata;
  assign count     = r_count;
  assign done      = r_done;
  assign full      = r_full;
  assign err       = r_err;

endmodule
